// File: rtl/mem_access_pkg.sv
// Shared constants, FSM state encoding and request record for the memory access unit.
package mem_access_pkg;

    localparam int LANE_W     = 12;
    localparam int LANES      = 6;
    localparam int MEM_WORDS  = 393216;
    localparam int REQ_ADDR_W = 19;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    typedef struct packed {
        logic                      write;
        logic                      vector;
        logic [REQ_ADDR_W-1:0]     addr;
        logic [LANES*LANE_W-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_access_unit.sv
// Purpose: single-outstanding scalar/6-lane load/store front end to a word memory, with range check.
// Latency: store resp 2 cycles, load READ_LAT+2, out-of-range 1 cycle after acceptance.
// Backpressure: req_ready only in IDLE; the response is held in RESP until resp_ready.
module mem_access_unit #(
    parameter int ADDR_W    = mem_access_pkg::REQ_ADDR_W,
    parameter int LANE_W    = mem_access_pkg::LANE_W,
    parameter int LANES     = mem_access_pkg::LANES,
    parameter int MEM_WORDS = mem_access_pkg::MEM_WORDS,
    parameter int READ_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic                      req_vector,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [LANES*LANE_W-1:0]   req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [LANES*LANE_W-1:0]   resp_rdata,
    output logic                      resp_err,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LANES*LANE_W-1:0]   mem_wdata,
    output logic                      mem_wren,
    output logic                      mem_mode,
    input  logic [LANES*LANE_W-1:0]   mem_rdata
);
    import mem_access_pkg::*;

    localparam int         VEC_SPAN = LANES - 1;
    localparam logic [1:0] LAT_LAST = 2'(READ_LAT);

    state_t                    state;
    mem_req_t                  req_q;
    logic [1:0]                lat_cnt;
    logic [ADDR_W:0]           last_addr;
    logic                      out_of_range;
    logic [LANES*LANE_W-1:0]   load_data;

    // The extra top bit keeps addr+5 from wrapping back into range.
    always_comb begin
        last_addr    = {1'b0, req_addr} + (req_vector ? (ADDR_W+1)'(VEC_SPAN) : '0);
        out_of_range = last_addr >= (ADDR_W+1)'(MEM_WORDS);
        load_data    = req_q.vector ? mem_rdata
                                    : {{(LANES-1)*LANE_W{1'b0}}, mem_rdata[LANE_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= '0;
            lat_cnt    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_wren   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q      <= '{write: req_write, vector: req_vector,
                                        addr: req_addr, wdata: req_wdata};
                        req_ready  <= 1'b0;
                        lat_cnt    <= '0;
                        resp_rdata <= '0;
                        resp_err   <= out_of_range;
                        if (out_of_range) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else if (req_write) begin
                            state    <= WRITE;
                            mem_wren <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                // Stores finish after their single write cycle; loads after READ_LAT+1 cycles.
                WRITE, READ: begin
                    if (state == WRITE || lat_cnt == LAT_LAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        mem_wren   <= 1'b0;
                        lat_cnt    <= '0;
                        resp_rdata <= req_q.write ? '0 : load_data;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_mode  = req_q.vector;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: unit 0 at READ_LAT=1, unit 1 at READ_LAT=3, sharing one word memory model.
`timescale 1ns/1ps
module tb_mem_access_unit;
    localparam int AW   = 19;
    localparam int DW   = 72;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam logic [DW-1:0] D7 = 72'h006_005_004_003_002_001;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          req_valid [2], req_ready [2], req_write [2], req_vector [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic          resp_valid[2], resp_ready[2], resp_err[2];
    logic [DW-1:0] resp_rdata[2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2], mem_rdata[2];
    logic          mem_wren  [2], mem_mode [2];

    mem_access_unit #(.READ_LAT(LAT0)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_vector(req_vector[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_wren(mem_wren[0]), .mem_mode(mem_mode[0]), .mem_rdata(mem_rdata[0]));

    mem_access_unit #(.READ_LAT(LAT1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_vector(req_vector[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_wren(mem_wren[1]), .mem_mode(mem_mode[1]), .mem_rdata(mem_rdata[1]));

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory model: reads sampled each edge and delayed READ_LAT cycles; unused scalar lanes carry junk.
    logic [11:0]   mem [int];
    logic          force_fff = 1'b0;
    logic [DW-1:0] pipe [2][3];
    int            wren_cnt [2] = '{0, 0};

    function automatic logic [11:0] rd_word(int a);
        if (mem.exists(a)) return mem[a];
        return 12'h000;
    endfunction

    function automatic logic [DW-1:0] rd_line(logic [AW-1:0] a, logic mode);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < 6; i++) begin
            if (force_fff)            d[i*12 +: 12] = 12'hFFF;
            else if (mode || i == 0)  d[i*12 +: 12] = rd_word(int'(a) + i);
            else                      d[i*12 +: 12] = 12'hA5C;
        end
        return d;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            pipe[u][2] = pipe[u][1];
            pipe[u][1] = pipe[u][0];
            pipe[u][0] = rd_line(mem_addr[u], mem_mode[u]);
        end
        for (int u = 0; u < 2; u++) begin
            if (mem_wren[u] === 1'b1) begin
                wren_cnt[u]++;
                for (int i = 0; i < 6; i++)
                    if (mem_mode[u] || i == 0)
                        mem[int'(mem_addr[u]) + i] = mem_wdata[u][i*12 +: 12];
            end
        end
    end

    always_comb begin
        mem_rdata[0] = pipe[0][LAT0-1];
        mem_rdata[1] = pipe[1][LAT1-1];
    end

    // Scoreboard: expectations queued at request drive, checked when resp_valid first rises.
    typedef struct { logic err; logic [DW-1:0] rdata; int lat; } exp_t;
    exp_t q0[$], q1[$];
    int   cyc  [2];
    bit   busy [2] = '{0, 0};
    bit   seen [2] = '{0, 0};

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                busy[u] = 0; seen[u] = 0;
            end else if (req_valid[u] && req_ready[u]) begin
                busy[u] = 1; seen[u] = 0; cyc[u] = 1;
            end else if (resp_valid[u] && resp_ready[u]) begin
                busy[u] = 0; seen[u] = 0;
            end else if (busy[u]) begin
                cyc[u]++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   empty;
        for (int u = 0; u < 2; u++) begin
            if (!rst && resp_valid[u] === 1'b1 && !seen[u]) begin
                seen[u] = 1;
                empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    total++; bad++;
                    $display("FAIL u%0d_unexpected_resp: got resp_valid=1 want none", u);
                end else begin
                    if (u == 0) e = q0.pop_front(); else e = q1.pop_front();
                    chk($sformatf("u%0d_resp_err", u), DW'(resp_err[u]), DW'(e.err));
                    chk($sformatf("u%0d_resp_rdata", u), resp_rdata[u], e.rdata);
                    chk($sformatf("u%0d_resp_latency", u), DW'(cyc[u]), DW'(e.lat));
                end
            end
        end
    end

    task automatic send(int u, logic w, logic v, logic [AW-1:0] a, logic [DW-1:0] wd,
                        logic e_err, logic [DW-1:0] e_rd, int e_lat, bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (req_ready[u] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[u] !== 1'b1) begin
            total++; bad++;
            $display("FAIL u%0d_req_ready_timeout: got req_ready=%b want 1", u, req_ready[u]);
            return;
        end
        req_valid[u] = 1'b1; req_write[u] = w; req_vector[u] = v;
        req_addr[u]  = a;    req_wdata[u] = wd;
        if (push) begin
            e.err = e_err; e.rdata = e_rd; e.lat = e_lat;
            if (u == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(negedge clk);
        req_valid[u] = 1'b0;
    endtask

    task automatic wait_done(int u);
        int n;
        n = 0;
        while (resp_valid[u] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (resp_valid[u] !== 1'b1) begin
            total++; bad++;
            $display("FAIL u%0d_resp_timeout: got resp_valid=%b want 1", u, resp_valid[u]);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic w; logic v; logic [AW-1:0] a; logic [DW-1:0] wd; bit fff;
        logic e_err; logic [DW-1:0] e_rd; int e_lat; int e_wren;
    } vec_t;

    function automatic vec_t mk(logic w, logic v, logic [AW-1:0] a, logic [DW-1:0] wd, bit fff,
                                logic e_err, logic [DW-1:0] e_rd, int e_lat, int e_wren);
        vec_t t;
        t.w = w; t.v = v; t.a = a; t.wd = wd; t.fff = fff;
        t.e_err = e_err; t.e_rd = e_rd; t.e_lat = e_lat; t.e_wren = e_wren;
        return t;
    endfunction

    vec_t tbl [14];

    initial begin
        int  w0;
        bit  saw;
        tbl[0]  = mk(1, 1, 7,      D7,                          0, 0, '0, 2, 1);
        tbl[1]  = mk(0, 1, 7,      '0,                          0, 0, D7, 3, 0);
        tbl[2]  = mk(0, 0, 8,      '0,                          1, 0, 72'hFFF, 3, 0);
        tbl[3]  = mk(0, 0, 8,      '0,                          0, 0, 72'h002, 3, 0);
        tbl[4]  = mk(1, 0, 393215, 72'hBBB_BBB_BBB_BBB_BBB_5A5, 0, 0, '0, 2, 1);
        tbl[5]  = mk(0, 1, 393210, '0,                          0, 0, 72'h5A5_000_000_000_000_000, 3, 0);
        tbl[6]  = mk(0, 1, 393211, '0,                          0, 1, '0, 1, 0);
        tbl[7]  = mk(1, 0, 393216, 72'h123,                     0, 1, '0, 1, 0);
        tbl[8]  = mk(0, 0, 393215, '0,                          0, 0, 72'h5A5, 3, 0);
        tbl[9]  = mk(1, 1, 393210, 72'h111_111_111_111_111_111, 0, 0, '0, 2, 1);
        tbl[10] = mk(1, 0, 393211, 72'h888_888_888_888_888_777, 0, 0, '0, 2, 1);
        tbl[11] = mk(0, 1, 393210, '0,                          0, 0, 72'h111_111_111_111_777_111, 3, 0);
        tbl[12] = mk(1, 1, 393211, 72'hFFF_FFF_FFF_FFF_FFF_FFF, 0, 1, '0, 1, 0);
        tbl[13] = mk(0, 1, 393210, '0,                          0, 0, 72'h111_111_111_111_777_111, 3, 0);

        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 0; req_write[u] = 0; req_vector[u] = 0;
            req_addr[u] = '0; req_wdata[u] = '0; resp_ready[u] = 1;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  DW'(req_ready[0]),  DW'(1));
        chk("rst_resp_valid", DW'(resp_valid[0]), DW'(0));
        chk("rst_resp_err",   DW'(resp_err[0]),   DW'(0));
        chk("rst_resp_rdata", resp_rdata[0],      '0);
        chk("rst_mem_wren",   DW'(mem_wren[0]),   DW'(0));
        chk("rst_mem_addr",   DW'(mem_addr[0]),   '0);
        chk("rst_mem_wdata",  mem_wdata[0],       '0);
        chk("rst_mem_mode",   DW'(mem_mode[0]),   DW'(0));
        chk("rst_u1_req_ready", DW'(req_ready[1]), DW'(1));
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            force_fff = tbl[i].fff;
            w0 = wren_cnt[0];
            send(0, tbl[i].w, tbl[i].v, tbl[i].a, tbl[i].wd,
                 tbl[i].e_err, tbl[i].e_rd, tbl[i].e_lat, 1);
            wait_done(0);
            force_fff = 1'b0;
            chk($sformatf("vec%0d_wren_pulses", i), DW'(wren_cnt[0] - w0), DW'(tbl[i].e_wren));
        end

        // Backpressure: response held for 5 cycles, then released.
        resp_ready[0] = 1'b0;
        send(0, 0, 1, 7, '0, 0, D7, 3, 1);
        for (int n = 0; n < 10 && resp_valid[0] !== 1'b1; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_resp_valid", k), DW'(resp_valid[0]), DW'(1));
            chk($sformatf("bp%0d_resp_rdata", k), resp_rdata[0], D7);
            chk($sformatf("bp%0d_req_ready", k),  DW'(req_ready[0]), DW'(0));
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_resp_valid", DW'(resp_valid[0]), DW'(0));
        chk("bp_release_req_ready",  DW'(req_ready[0]),  DW'(1));

        // Reset during READ discards the load.
        send(0, 0, 1, 7, '0, 0, '0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rd_rst_resp_valid", DW'(resp_valid[0]), DW'(0));
        chk("rd_rst_req_ready",  DW'(req_ready[0]),  DW'(1));
        chk("rd_rst_mem_wren",   DW'(mem_wren[0]),   DW'(0));
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[0] === 1'b1) saw = 1;
        end
        chk("rd_rst_no_resp", DW'(saw), DW'(0));
        send(0, 0, 1, 7, '0, 0, D7, 3, 1);
        wait_done(0);

        // Reset during WRITE: only the pulse already on the bus, no response.
        w0 = wren_cnt[0];
        send(0, 1, 0, 30, 72'h321, 0, '0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid[0] === 1'b1 || mem_wren[0] === 1'b1) saw = 1;
        end
        chk("wr_rst_quiet", DW'(saw), DW'(0));
        chk("wr_rst_wren_pulses", DW'(wren_cnt[0] - w0), DW'(1));

        // Reset during RESP drops the held response.
        resp_ready[0] = 1'b0;
        send(0, 0, 1, 393211, '0, 1, '0, 1, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("resp_rst_resp_valid", DW'(resp_valid[0]), DW'(0));
        chk("resp_rst_resp_err",   DW'(resp_err[0]),   DW'(0));
        chk("resp_rst_req_ready",  DW'(req_ready[0]),  DW'(1));
        resp_ready[0] = 1'b1;

        // Longer read latency on unit 1.
        w0 = wren_cnt[1];
        send(1, 1, 1, 7, D7, 0, '0, 2, 1);
        wait_done(1);
        chk("lat3_wren_pulses", DW'(wren_cnt[1] - w0), DW'(1));
        send(1, 0, 1, 7, '0, 0, D7, 5, 1);
        wait_done(1);
        send(1, 0, 0, 8, '0, 0, 72'h002, 5, 1);
        wait_done(1);

        repeat (2) @(negedge clk);
        chk("queue0_drained", DW'(q0.size()), DW'(0));
        chk("queue1_drained", DW'(q1.size()), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish within 1ms");
        $fatal(1);
    end

endmodule
